// File: rtl/store_drain_unit_pkg.sv
// Shared load/store-unit types: drain FSM states, default geometry, head-entry qualification.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package store_drain_unit_pkg;

  localparam int SDU_XLEN          = 32;
  localparam int SDU_ROB_TAG_WIDTH = 5;
  localparam int SDU_STQ_SIZE      = 8;
  localparam int SDU_STQ_TAG_WIDTH = 4;
  localparam int SDU_MAX_RETRIES   = 3;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    RETIRE,
    FAULT
  } drain_state_t;

  // A store may leave the STQ only once it is committed, fully formed, and
  // has not already been sent or acknowledged.
  function automatic logic entry_eligible(
    input logic vld,
    input logic committed,
    input logic addr_vld,
    input logic data_vld,
    input logic executed,
    input logic succeeded
  );
    return vld & committed & addr_vld & data_vld & ~executed & ~succeeded;
  endfunction

endpackage

// File: rtl/store_drain_unit_if.sv
// Data-memory write port: request valid/ready handshake plus write response.
// Latency: n/a (wiring only).
// Backpressure: request side stalls on mem_req_ready; response side has no backpressure.
interface store_drain_unit_if
  import store_drain_unit_pkg::*;
#(
  parameter int XLEN = SDU_XLEN
) ();

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic [XLEN-1:0] mem_req_data;
  logic            mem_resp_valid;
  logic            mem_resp_error;

  // Issuer of write requests (the drain unit).
  modport master (
    output mem_req_valid,
    output mem_req_addr,
    output mem_req_data,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_error
  );

  // Memory side.
  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    input  mem_req_data,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_error
  );

endinterface

// File: rtl/store_drain_unit.sv
// Drains committed stores from the STQ head to the data-memory write port in program order.
// Latency: request issued 1 cycle after head is eligible; at most one store per 5 cycles.
// Backpressure: request held stable until mem_req_ready; one store outstanding; error responses retried.
module store_drain_unit
  import store_drain_unit_pkg::*;
#(
  parameter int XLEN          = SDU_XLEN,
  parameter int ROB_TAG_WIDTH = SDU_ROB_TAG_WIDTH,
  parameter int STQ_SIZE      = SDU_STQ_SIZE,
  parameter int STQ_TAG_WIDTH = SDU_STQ_TAG_WIDTH,
  parameter int MAX_RETRIES   = SDU_MAX_RETRIES
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [STQ_SIZE-1:0]                     i_stq_valid,
  input  logic [STQ_SIZE-1:0]                     i_stq_address_valid,
  input  logic [STQ_SIZE-1:0]                     i_stq_data_valid,
  input  logic [STQ_SIZE-1:0]                     i_stq_committed,
  input  logic [STQ_SIZE-1:0]                     i_stq_executed,
  input  logic [STQ_SIZE-1:0]                     i_stq_succeeded,
  input  logic [STQ_SIZE-1:0][XLEN-1:0]           i_stq_address,
  input  logic [STQ_SIZE-1:0][XLEN-1:0]           i_stq_data,
  input  logic [STQ_SIZE-1:0][ROB_TAG_WIDTH-1:0]  i_stq_rob_tag,
  input  logic [STQ_TAG_WIDTH-1:0]                i_head,
  output logic                                    o_store_fired,
  output logic [$clog2(STQ_SIZE)-1:0]             o_store_fired_index,
  output logic                                    o_store_succeeded,
  output logic [ROB_TAG_WIDTH-1:0]                o_store_succeeded_rob_tag,
  output logic                                    o_busy,
  output logic                                    o_fault,
  store_drain_unit_if.master                      mem
);

  localparam int IDX_W = $clog2(STQ_SIZE);
  localparam int CNT_W = $clog2(MAX_RETRIES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RETRIES);

  drain_state_t              r_state;
  logic [STQ_TAG_WIDTH-1:0]  r_head;
  logic [XLEN-1:0]           r_addr;
  logic [XLEN-1:0]           r_data;
  logic [ROB_TAG_WIDTH-1:0]  r_tag;
  logic [CNT_W-1:0]          r_retry_cnt;
  logic                      r_fired;
  logic                      r_succ;
  logic                      r_req_vld;
  logic                      r_busy;
  logic                      r_fault;

  logic [IDX_W-1:0]          w_head_idx;
  logic                      w_eligible;

  // Head-entry mux: only the oldest store is ever considered.
  assign w_head_idx = i_head[IDX_W-1:0];
  assign w_eligible = entry_eligible(i_stq_valid[w_head_idx],
                                     i_stq_committed[w_head_idx],
                                     i_stq_address_valid[w_head_idx],
                                     i_stq_data_valid[w_head_idx],
                                     i_stq_executed[w_head_idx],
                                     i_stq_succeeded[w_head_idx]);

  // Drain FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_head      <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_tag       <= '0;
      r_retry_cnt <= '0;
      r_fired     <= 1'b0;
      r_succ      <= 1'b0;
      r_req_vld   <= 1'b0;
      r_busy      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      // Status pulses last exactly one cycle.
      r_fired <= 1'b0;
      r_succ  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_eligible) begin
            r_state   <= REQ;
            r_head    <= i_head;
            r_addr    <= i_stq_address[w_head_idx];
            r_data    <= i_stq_data[w_head_idx];
            r_tag     <= i_stq_rob_tag[w_head_idx];
            r_fired   <= 1'b1;
            r_req_vld <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        REQ: begin
          // Address/data are not touched here, so they stay stable while stalled.
          if (mem.mem_req_ready) begin
            r_state   <= WAIT_RESP;
            r_req_vld <= 1'b0;
          end
        end
        WAIT_RESP: begin
          if (mem.mem_resp_valid) begin
            if (!mem.mem_resp_error) begin
              r_state <= RETIRE;
              r_succ  <= 1'b1;
            end else if (r_retry_cnt < MAX_CNT) begin
              // Replay the latched store; the STQ already knows it fired.
              r_state     <= REQ;
              r_retry_cnt <= r_retry_cnt + 1'b1;
              r_req_vld   <= 1'b1;
            end else begin
              r_state <= FAULT;
              r_fault <= 1'b1;
            end
          end
        end
        RETIRE: begin
          // Full pointer compare so a wrap back to the same index still counts as movement.
          if (i_head != r_head) begin
            r_state     <= IDLE;
            r_retry_cnt <= '0;
            r_busy      <= 1'b0;
          end
        end
        FAULT: begin
          r_state <= FAULT;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_store_fired             = r_fired;
  assign o_store_fired_index       = r_head[IDX_W-1:0];
  assign o_store_succeeded         = r_succ;
  assign o_store_succeeded_rob_tag = r_tag;
  assign o_busy                    = r_busy;
  assign o_fault                   = r_fault;

  assign mem.mem_req_valid = r_req_vld;
  assign mem.mem_req_addr  = r_addr;
  assign mem.mem_req_data  = r_data;

endmodule

// File: tb/tb_store_drain_unit.sv
// Directed bench for store_drain_unit with an STQ model, a memory model and a scoreboard.
// Latency: n/a.
// Backpressure: memory model stalls ready and injects error responses on request.
module tb_store_drain_unit;
  import store_drain_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;

  logic [7:0]        stq_valid, stq_address_valid, stq_data_valid;
  logic [7:0]        stq_committed, stq_executed, stq_succeeded;
  logic [7:0][31:0]  stq_address, stq_data;
  logic [7:0][4:0]   stq_rob_tag;
  logic [3:0]        head;

  logic        store_fired;
  logic [2:0]  store_fired_index;
  logic        store_succeeded;
  logic [4:0]  store_succeeded_rob_tag;
  logic        busy, fault;

  store_drain_unit_if #(.XLEN(32)) mem_if ();

  store_drain_unit dut (
    .clk                       (clk),
    .reset                     (reset),
    .i_stq_valid               (stq_valid),
    .i_stq_address_valid       (stq_address_valid),
    .i_stq_data_valid          (stq_data_valid),
    .i_stq_committed           (stq_committed),
    .i_stq_executed            (stq_executed),
    .i_stq_succeeded           (stq_succeeded),
    .i_stq_address             (stq_address),
    .i_stq_data                (stq_data),
    .i_stq_rob_tag             (stq_rob_tag),
    .i_head                    (head),
    .o_store_fired             (store_fired),
    .o_store_fired_index       (store_fired_index),
    .o_store_succeeded         (store_succeeded),
    .o_store_succeeded_rob_tag (store_succeeded_rob_tag),
    .o_busy                    (busy),
    .o_fault                   (fault),
    .mem                       (mem_if)
  );

  always #5 clk = ~clk;

  // Scoreboard and bookkeeping.
  logic [63:0] exp_req[$];
  logic [2:0]  exp_idx[$];
  logic [4:0]  exp_tag[$];
  int          fire_cyc[$];
  int n_pass = 0, n_total = 0;
  int n_fired = 0, n_req = 0, n_succ = 0, n_stall = 0, cyc = 0;
  int stall_left = 0, err_left = 0;
  bit resp_pending = 1'b0, clr_pending = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_stq();
    stq_valid = '0; stq_address_valid = '0; stq_data_valid = '0;
    stq_committed = '0; stq_executed = '0; stq_succeeded = '0;
    stq_address = '0; stq_data = '0; stq_rob_tag = '0;
  endtask

  task automatic load_entry(input int idx, input logic [31:0] addr, input logic [31:0] data,
                            input logic [4:0] tag, input logic commit, input int n_reqs);
    stq_valid[idx] = 1'b1; stq_address_valid[idx] = 1'b1; stq_data_valid[idx] = 1'b1;
    stq_committed[idx] = commit; stq_executed[idx] = 1'b0; stq_succeeded[idx] = 1'b0;
    stq_address[idx] = addr; stq_data[idx] = data; stq_rob_tag[idx] = tag;
    for (int k = 0; k < n_reqs; k++) exp_req.push_back({addr, data});
    exp_idx.push_back(3'(idx));
    exp_tag.push_back(tag);
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && !(n_succ >= target && !busy); i++) @(negedge clk);
    check(tag, 64'(n_succ), 64'(target));
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  // Memory model: decides ready for the coming edge, answers one cycle after acceptance.
  initial begin
    forever begin
      @(negedge clk);
      mem_if.mem_req_ready  = 1'b0;
      mem_if.mem_resp_valid = 1'b0;
      mem_if.mem_resp_error = 1'b0;
      if (!reset) begin
        resp_pending = 1'b0;
      end else begin
        if (resp_pending) begin
          mem_if.mem_resp_valid = 1'b1;
          mem_if.mem_resp_error = (err_left > 0);
          if (err_left > 0) err_left--;
          resp_pending = 1'b0;
        end
        if (mem_if.mem_req_valid) begin
          if (stall_left > 0) begin
            stall_left--;
            n_stall++;
            check("stall_held", {mem_if.mem_req_addr, mem_if.mem_req_data},
                  (exp_req.size() > 0) ? exp_req[0] : 64'bx);
          end else begin
            mem_if.mem_req_ready = 1'b1;
            n_req++;
            resp_pending = 1'b1;
            check("req_addr_data", {mem_if.mem_req_addr, mem_if.mem_req_data},
                  (exp_req.size() > 0) ? exp_req.pop_front() : 64'bx);
          end
        end
      end
    end
  end

  // STQ model: marks fired entries executed, retires two edges after the success pulse.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (clr_pending) begin
        stq_valid[head[2:0]] = 1'b0; stq_committed[head[2:0]] = 1'b0;
        stq_address_valid[head[2:0]] = 1'b0; stq_data_valid[head[2:0]] = 1'b0;
        stq_executed[head[2:0]] = 1'b0; stq_succeeded[head[2:0]] = 1'b0;
        head = head + 4'd1;
        clr_pending = 1'b0;
      end
      if (store_fired) begin
        n_fired++;
        fire_cyc.push_back(cyc);
        check("fired_idx", 64'(store_fired_index),
              (exp_idx.size() > 0) ? 64'(exp_idx.pop_front()) : 64'bx);
        stq_executed[store_fired_index] = 1'b1;
      end
      if (store_succeeded) begin
        n_succ++;
        check("succ_tag", 64'(store_succeeded_rob_tag),
              (exp_tag.size() > 0) ? 64'(exp_tag.pop_front()) : 64'bx);
        stq_succeeded[head[2:0]] = 1'b1;
        clr_pending = 1'b1;
      end
    end
  end

  initial begin
    int f0, r0, s0;
    reset = 1'b0;
    head  = '0;
    clear_stq();
    mem_if.mem_req_ready = 1'b0; mem_if.mem_resp_valid = 1'b0; mem_if.mem_resp_error = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_fired", 64'(store_fired), 64'd0);
    check("rst_succ", 64'(store_succeeded), 64'd0);
    check("rst_req_vld", 64'(mem_if.mem_req_valid), 64'd0);
    check("rst_addr", 64'(mem_if.mem_req_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: basic store, zero-wait memory.
    load_entry(0, 32'h100, 32'hDEAD, 5'd5, 1'b1, 1);
    @(negedge clk);
    check("t1_fired_next", 64'(store_fired), 64'd1);
    check("t1_req_vld", 64'(mem_if.mem_req_valid), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done("t1_succ", 1, 40);
    check("t1_nfired", 64'(n_fired), 64'd1);

    // 2: ready held low 3 cycles.
    stall_left = 3;
    load_entry(1, 32'h204, 32'hCAFE_F00D, 5'd9, 1'b1, 1);
    wait_done("t2_succ", 2, 40);
    check("t2_stall_cycles", 64'(n_stall), 64'd3);
    check("t2_nreq", 64'(n_req), 64'd2);

    // 3: uncommitted head waits for commit.
    load_entry(2, 32'h308, 32'h1234_5678, 5'd17, 1'b0, 1);
    repeat (6) @(negedge clk);
    check("t3_no_fire", 64'(n_fired), 64'd2);
    check("t3_no_req", 64'(mem_if.mem_req_valid), 64'd0);
    stq_committed[2] = 1'b1;
    @(negedge clk);
    check("t3_fire_on_commit", 64'(store_fired), 64'd1);
    wait_done("t3_succ", 3, 40);

    // 4: two error responses then success.
    f0 = n_fired; r0 = n_req;
    err_left = 2;
    load_entry(3, 32'h40C, 32'hA5A5_5A5A, 5'd30, 1'b1, 3);
    wait_done("t4_succ", 4, 60);
    check("t4_nreq", 64'(n_req - r0), 64'd3);
    check("t4_nfired", 64'(n_fired - f0), 64'd1);

    // 6a: back-to-back stores across the head wrap 7 -> 8.
    fire_cyc.delete();
    load_entry(4, 32'h500, 32'h0000_0004, 5'd1, 1'b1, 1);
    load_entry(5, 32'h504, 32'h0000_0005, 5'd2, 1'b1, 1);
    load_entry(6, 32'h508, 32'h0000_0006, 5'd3, 1'b1, 1);
    load_entry(7, 32'h50C, 32'h0000_0007, 5'd4, 1'b1, 1);
    load_entry(0, 32'h510, 32'h0000_0008, 5'd6, 1'b1, 1);
    load_entry(1, 32'h514, 32'h0000_0009, 5'd7, 1'b1, 1);
    wait_done("t6_succ", 10, 120);
    check("t6_head", 64'(head), 64'd10);
    check("t6_nfires", 64'(fire_cyc.size()), 64'd6);
    if (fire_cyc.size() == 6) check("t6_rate", 64'(fire_cyc[5] - fire_cyc[0]), 64'd25);

    // 5: retries exhausted -> sticky fault.
    f0 = n_fired; s0 = n_succ;
    err_left = 4;
    load_entry(2, 32'h600, 32'hBAD0_BAD0, 5'd11, 1'b1, 4);
    for (int i = 0; i < 80 && !fault; i++) @(negedge clk);
    check("t5_fault", 64'(fault), 64'd1);
    r0 = n_req;
    repeat (10) @(negedge clk);
    check("t5_fault_sticky", 64'(fault), 64'd1);
    check("t5_busy", 64'(busy), 64'd1);
    check("t5_no_more_req", 64'(n_req - r0), 64'd0);
    check("t5_req_vld", 64'(mem_if.mem_req_valid), 64'd0);
    check("t5_nfired", 64'(n_fired - f0), 64'd1);
    check("t5_no_succ", 64'(n_succ - s0), 64'd0);

    // Recover from fault via reset.
    reset = 1'b0;
    clear_stq(); head = '0;
    exp_req.delete(); exp_idx.delete(); exp_tag.delete();
    clr_pending = 1'b0; err_left = 0;
    @(negedge clk);
    check("rec_fault_clr", 64'(fault), 64'd0);
    reset = 1'b1;

    // 6b: reset while the request is stalled.
    stall_left = 100;
    load_entry(0, 32'h700, 32'h7777_0000, 5'd21, 1'b1, 1);
    @(negedge clk);
    check("t6r_fired", 64'(store_fired), 64'd1);
    repeat (2) @(negedge clk);
    check("t6r_in_req", 64'(mem_if.mem_req_valid), 64'd1);
    f0 = n_fired;
    reset = 1'b0;
    #1;
    check("t6r_vld_drop", 64'(mem_if.mem_req_valid), 64'd0);
    check("t6r_addr_clr", 64'(mem_if.mem_req_addr), 64'd0);
    check("t6r_busy_clr", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    stall_left = 0;
    repeat (6) @(negedge clk);
    check("t6r_no_reissue", 64'(n_fired - f0), 64'd0);
    check("t6r_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
